// File: rtl/i2c_master_write.sv
// I2C master, write-only: START, {addr,W}, ACK, reg byte, ACK, data byte, ACK, STOP.
// Each bit period is four phases of CLK_DIV clocks. SCL is low in P0/P1 and high in P2/P3.
// SDA is updated at the start of P0, and the slave's ACK is sampled on the first cycle of P3.
// Ports:
//   clk, reset           system clock; synchronous active-low reset
//   start_i              one-cycle request; captures slave_addr_i/reg_addr_i/data_i
//   SDA_i                sampled bus SDA level (ACK detection)
//   SCL_o                SCL drive level
//   SDA_o, SDA_oe_o      SDA drive value and enable (0 = released)
//   busy_o               transaction in progress
//   done_o, ack_err_o    end-of-transaction pulse; NACK flag held until the next start
module i2c_master_write #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [6:0] slave_addr_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] data_i,
  input  logic       SDA_i,
  output logic       SCL_o,
  output logic       SDA_o,
  output logic       SDA_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o
);

  typedef enum logic [3:0] {
    StIdle, StStart, StAddr, StAckA, StReg, StAckR, StData, StAckD, StStop
  } state_e;

  localparam logic [7:0] QLast = 8'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] qcnt_q, qcnt_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] data_q, data_d;
  logic       nack_q, nack_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic       ack_err_q, ack_err_d;

  logic [7:0] cur_byte;
  logic [2:0] bit_idx;
  logic       is_ack;

  assign bit_idx = (MSB_FIRST != 0) ? (3'd7 - bit_q) : bit_q;
  assign is_ack  = (state_q == StAckA) || (state_q == StAckR) || (state_q == StAckD);

  always_comb begin
    cur_byte = 8'h00;
    case (state_q)
      StAddr:  cur_byte = {addr_q, 1'b0};
      StReg:   cur_byte = reg_q;
      StData:  cur_byte = data_q;
      default: cur_byte = 8'h00;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q + 8'd1;
    phase_d   = phase_q;
    bit_d     = bit_q;
    addr_d    = addr_q;
    reg_d     = reg_q;
    data_d    = data_q;
    nack_d    = nack_q;
    err_d     = err_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;

    if (state_q == StIdle) begin
      qcnt_d  = 8'd0;
      phase_d = 2'd0;
      bit_d   = 3'd0;
      if (start_i) begin
        addr_d    = slave_addr_i;
        reg_d     = reg_addr_i;
        data_d    = data_i;
        err_d     = 1'b0;
        ack_err_d = 1'b0;
        state_d   = StStart;
      end
    end else begin
      if (is_ack && phase_q == 2'd3 && qcnt_q == 8'd0) begin
        nack_d = SDA_i;
      end
      if (qcnt_q == QLast) begin
        qcnt_d  = 8'd0;
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          bit_d = 3'd0;
          unique case (state_q)
            StStart: state_d = StAddr;
            StAddr, StReg, StData: begin
              if (bit_q == 3'd7) begin
                state_d = (state_q == StAddr) ? StAckA :
                          (state_q == StReg)  ? StAckR : StAckD;
              end else begin
                bit_d = bit_q + 3'd1;
              end
            end
            StAckA, StAckR, StAckD: begin
              if (nack_q) begin
                err_d   = 1'b1;
                state_d = StStop;
              end else begin
                state_d = (state_q == StAckA) ? StReg :
                          (state_q == StAckR) ? StData : StStop;
              end
            end
            StStop: begin
              state_d   = StIdle;
              done_d    = 1'b1;
              ack_err_d = err_q;
            end
            default: state_d = StIdle;
          endcase
        end
      end
    end
  end

  // Bus outputs are decoded from state and phase so they follow reset on the same edge
  always_comb begin
    SCL_o    = 1'b1;
    SDA_o    = 1'b1;
    SDA_oe_o = 1'b0;
    case (state_q)
      StStart: begin
        SDA_oe_o = phase_q[1];
        SDA_o    = ~phase_q[1];
      end
      StAddr, StReg, StData: begin
        SCL_o    = phase_q[1];
        SDA_oe_o = 1'b1;
        SDA_o    = cur_byte[bit_idx];
      end
      StAckA, StAckR, StAckD: begin
        SCL_o = phase_q[1];
      end
      StStop: begin
        // SDA rises while SCL is high in P3: the STOP condition
        SCL_o    = phase_q[1];
        SDA_oe_o = (phase_q != 2'd3);
        SDA_o    = (phase_q == 2'd3);
      end
      default: ;
    endcase
  end

  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign ack_err_o = ack_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      qcnt_q    <= 8'd0;
      phase_q   <= 2'd0;
      bit_q     <= 3'd0;
      addr_q    <= 7'd0;
      reg_q     <= 8'd0;
      data_q    <= 8'd0;
      nack_q    <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      addr_q    <= addr_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      nack_q    <= nack_d;
      err_q     <= err_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_write.sv
// Bench for i2c_master_write: vector table of write transactions against a bus-level
// slave model, plus hand sequences for reset, start-during-busy and mid-transaction reset.
module tb_i2c_master_write;

  logic       clk;
  logic       reset;
  logic       start_i;
  logic [6:0] slave_addr_i;
  logic [7:0] reg_addr_i;
  logic [7:0] data_i;
  logic       SDA_i;
  logic       SCL_o;
  logic       SDA_o;
  logic       SDA_oe_o;
  logic       busy_o;
  logic       done_o;
  logic       ack_err_o;

  i2c_master_write #(.CLK_DIV(4), .MSB_FIRST(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .slave_addr_i (slave_addr_i),
    .reg_addr_i   (reg_addr_i),
    .data_i       (data_i),
    .SDA_i        (SDA_i),
    .SCL_o        (SCL_o),
    .SDA_o        (SDA_o),
    .SDA_oe_o     (SDA_oe_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .ack_err_o    (ack_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] rg;
    logic [7:0] dat;
    logic [2:0] nack;   // bit k set: slave NACKs the k-th ACK slot
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         lat;
    logic       err;
  } vec_t;

  vec_t vecs[6];

  int tests_run = 0;
  int tests_failed = 0;

  // Slave model and bus monitor state
  logic [2:0] nack_mask = 3'b000;
  logic [7:0] bytes_seen[4];
  logic [7:0] sh;
  int         nbytes_seen = 0;
  int         bitcnt = 0;
  int         ackidx = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         done_cnt = 0;
  logic       prev_scl = 1'b1;
  logic       prev_line = 1'b1;
  logic       line;

  always @(negedge clk) begin
    if (!reset) begin
      bitcnt    = 0;
      SDA_i     = 1'b1;
      prev_scl  = 1'b1;
      prev_line = 1'b1;
    end else begin
      line = SDA_oe_o ? SDA_o : 1'b1;
      // SDA moving while SCL stays high is only START (fall) or STOP (rise)
      if (prev_scl && SCL_o && line != prev_line) begin
        if (!line) begin
          start_cnt++;
          nbytes_seen = 0;
          bitcnt = 0;
          ackidx = 0;
        end else begin
          stop_cnt++;
        end
      end
      if (!prev_scl && SCL_o) begin
        if (bitcnt < 8) begin
          sh = {sh[6:0], line};
          bitcnt++;
          if (bitcnt == 8) begin
            if (nbytes_seen < 4) bytes_seen[nbytes_seen] = sh;
            nbytes_seen++;
            SDA_i = (ackidx < 3) ? nack_mask[ackidx] : 1'b1;
          end
        end else begin
          bitcnt = 0;
          ackidx++;
        end
      end
      if (prev_scl && !SCL_o && bitcnt == 0) SDA_i = 1'b1;
      if (done_o) done_cnt++;
      prev_scl  = SCL_o;
      prev_line = line;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issues one transaction; optionally pulses start_i with other operands at cycle busy_at.
  // lat is the number of clocks from the accepting edge to the done_o pulse (-1 on timeout).
  task automatic run_txn(input vec_t v, input int busy_at, output int lat, output logic err);
    nack_mask = v.nack;
    @(negedge clk);
    slave_addr_i = v.addr;
    reg_addr_i   = v.rg;
    data_i       = v.dat;
    start_i      = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    lat = -1;
    err = 1'b0;
    for (int c = 0; c <= 2000; c++) begin
      @(negedge clk);
      if (c == busy_at) begin
        slave_addr_i = 7'h33;
        reg_addr_i   = 8'h11;
        data_i       = 8'hEE;
        start_i      = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) begin
        lat = c;
        err = ack_err_o;
        break;
      end
    end
  endtask

  task automatic check_txn(input string tag, input vec_t v, input int busy_at);
    int   lat;
    logic err;
    int   s0, p0, d0;
    s0 = start_cnt;
    p0 = stop_cnt;
    d0 = done_cnt;
    run_txn(v, busy_at, lat, err);
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " ack_err at done"}, int'(err), int'(v.err));
    @(negedge clk);
    chk({tag, " done one cycle"}, int'(done_o), 0);
    chk({tag, " busy after done"}, int'(busy_o), 0);
    @(negedge clk);
    chk({tag, " ack_err held"}, int'(ack_err_o), int'(v.err));
    chk({tag, " done pulses"}, done_cnt - d0, 1);
    chk({tag, " start conds"}, start_cnt - s0, 1);
    chk({tag, " stop conds"}, stop_cnt - p0, 1);
    chk({tag, " bytes on bus"}, nbytes_seen, v.nbytes);
    if (v.nbytes > 0) chk({tag, " byte0"}, int'(bytes_seen[0]), int'(v.b0));
    if (v.nbytes > 1) chk({tag, " byte1"}, int'(bytes_seen[1]), int'(v.b1));
    if (v.nbytes > 2) chk({tag, " byte2"}, int'(bytes_seen[2]), int'(v.b2));
  endtask

  initial begin
    // addr, reg, data, nack mask, bytes, byte0 ({addr,0}), byte1, byte2, latency, err
    vecs[0] = '{7'h4B, 8'hAB, 8'h5A, 3'b000, 3, 8'h96, 8'hAB, 8'h5A, 464, 1'b0};
    vecs[1] = '{7'h12, 8'hAB, 8'h5A, 3'b111, 1, 8'h24, 8'h00, 8'h00, 176, 1'b1};
    vecs[2] = '{7'h4B, 8'hAB, 8'h5A, 3'b100, 3, 8'h96, 8'hAB, 8'h5A, 464, 1'b1};
    vecs[3] = '{7'h7F, 8'h00, 8'hFF, 3'b000, 3, 8'hFE, 8'h00, 8'hFF, 464, 1'b0};
    vecs[4] = '{7'h00, 8'hC3, 8'h3C, 3'b010, 2, 8'h00, 8'hC3, 8'h00, 320, 1'b1};
    vecs[5] = '{7'h55, 8'h81, 8'h7E, 3'b000, 3, 8'hAA, 8'h81, 8'h7E, 464, 1'b0};

    // Reset with start_i held high: start must be ignored
    reset        = 1'b0;
    start_i      = 1'b1;
    slave_addr_i = 7'h00;
    reg_addr_i   = 8'h00;
    data_i       = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset SCL_o", int'(SCL_o), 1);
    chk("reset SDA_o", int'(SDA_o), 1);
    chk("reset SDA_oe_o", int'(SDA_oe_o), 0);
    chk("reset busy_o", int'(busy_o), 0);
    chk("reset done_o", int'(done_o), 0);
    chk("reset ack_err_o", int'(ack_err_o), 0);
    reset   = 1'b1;
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("start during reset ignored", int'(busy_o), 0);

    for (int i = 0; i < 6; i++) begin
      check_txn($sformatf("vec%0d", i), vecs[i], -1);
    end

    // Start pulse at cycle 100 of an active transaction must change nothing
    check_txn("busy start", vecs[0], 100);

    // Reset for one cycle during DATA bit 3 (cycle 352 = 16+128+16+128+16+3*16)
    begin
      int s0, p0, d0;
      s0 = start_cnt;
      p0 = stop_cnt;
      d0 = done_cnt;
      nack_mask = 3'b000;
      @(negedge clk);
      slave_addr_i = vecs[0].addr;
      reg_addr_i   = vecs[0].rg;
      data_i       = vecs[0].dat;
      start_i      = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      for (int c = 0; c <= 352; c++) begin
        @(negedge clk);
        if (c == 352) reset = 1'b0;
      end
      @(negedge clk);
      chk("midreset SCL_o", int'(SCL_o), 1);
      chk("midreset SDA_oe_o", int'(SDA_oe_o), 0);
      chk("midreset busy_o", int'(busy_o), 0);
      reset = 1'b1;
      repeat (600) @(negedge clk);
      chk("midreset no done", done_cnt - d0, 0);
      chk("midreset no stop", stop_cnt - p0, 0);
      chk("midreset one start", start_cnt - s0, 1);
    end
    check_txn("after reset", vecs[0], -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
